// File: rtl/mul_share_arbiter.sv
// Round-robin front end sharing one pipelined 32x32 multiplier
// between two requesters, with product steering by tag pipe.
module mul_share_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_s,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [63:0] resp_data,
  output logic        busy
);

  logic               last_q, last_d;
  logic               issue_vld_q, issue_vld_d;
  logic               issue_id_q, issue_id_d;
  logic [31:0]        mul_a_q, mul_a_d;
  logic [31:0]        mul_b_q, mul_b_d;
  logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [LATENCY-1:0] tag_id_q, tag_id_d;
  logic               gnt0, gnt1;

  // grant: ties go to the requester that was not served last
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  // issue stage and ownership tag shift
  always_comb begin
    last_d      = last_q;
    issue_vld_d = gnt0 | gnt1;
    issue_id_d  = issue_id_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    if (gnt0) begin
      mul_a_d    = req0_a;
      mul_b_d    = req0_b;
      issue_id_d = 1'b0;
      last_d     = 1'b0;
    end else if (gnt1) begin
      mul_a_d    = req1_a;
      mul_b_d    = req1_b;
      issue_id_d = 1'b1;
      last_d     = 1'b1;
    end
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = issue_vld_q;
    tag_id_d[0]  = issue_id_q;
    for (int i = 1; i < LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  // state registers; reset flushes every in-flight tag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q      <= 1'b1;
      issue_vld_q <= 1'b0;
      issue_id_q  <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
    end else begin
      last_q      <= last_d;
      issue_vld_q <= issue_vld_d;
      issue_id_q  <= issue_id_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
    end
  end

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign resp0_valid = tag_vld_q[LATENCY-1] & ~tag_id_q[LATENCY-1];
  assign resp1_valid = tag_vld_q[LATENCY-1] & tag_id_q[LATENCY-1];
  assign resp_data   = (resp0_valid | resp1_valid) ? mul_s : '0;
  assign busy        = issue_vld_q | (|tag_vld_q);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: queue-based response model,
// directed cases from the plan, then randomized traffic.
module tb_mul_share_arbiter;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_s;
  logic        resp0_valid, resp1_valid;
  logic [63:0] resp_data;
  logic        busy;

  mul_share_arbiter #(.LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_s(mul_s),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_data(resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // stand-in multiplier: L-stage pipe, not affected by reset
  logic [63:0] mp [L];
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) mp[i] <= mp[i-1];
    mp[0] <= 64'(mul_a) * 64'(mul_b);
  end
  assign mul_s = mp[L-1];

  typedef struct {
    int          due;
    bit          id;
    logic [63:0] p;
  } exp_t;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  exp_t eq[$];
  op_t  q0[$];
  op_t  q1[$];
  int   cyc = 0;
  bit   m_last = 1'b1;
  bit   acc0, acc1;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   mw;

  function automatic int pick(bit v0, bit v1, bit last);
    if (v0 && v1) return last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h",
               name, cyc, act, exp);
    end
  endtask

  // model: accepted pairs become expected responses
  always @(posedge clk) begin
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!rst_n) begin
      eq.delete();
      m_last = 1'b1;
    end else begin
      mw = pick(req0_valid, req1_valid, m_last);
      if (mw == 0) begin
        acc0 = 1'b1;
        m_last = 1'b0;
        eq.push_back('{due: cyc + 1 + L, id: 1'b0,
                       p: 64'(req0_a) * 64'(req0_b)});
      end else if (mw == 1) begin
        acc1 = 1'b1;
        m_last = 1'b1;
        eq.push_back('{due: cyc + 1 + L, id: 1'b1,
                       p: 64'(req1_a) * 64'(req1_b)});
      end
    end
    cyc++;
  end

  // compare DUT against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      int w;
      bit e0, e1;
      logic [63:0] ed;
      w = rst_n ? pick(req0_valid, req1_valid, m_last) : -1;
      chk("ready0", req0_ready, w == 0);
      chk("ready1", req1_ready, w == 1);
      chk("busy", busy, eq.size() > 0);
      e0 = 1'b0;
      e1 = 1'b0;
      ed = '0;
      if (eq.size() > 0 && eq[0].due == cyc) begin
        e0 = !eq[0].id;
        e1 = eq[0].id;
        ed = eq[0].p;
        eq.delete(0);
      end
      chk("resp0_valid", resp0_valid, e0);
      chk("resp1_valid", resp1_valid, e1);
      chk("resp_data", resp_data, ed);
    end
  end

  task automatic drive();
    req0_valid = q0.size() > 0;
    req1_valid = q1.size() > 0;
    if (req0_valid) begin
      req0_a = q0[0].a;
      req0_b = q0[0].b;
    end
    if (req1_valid) begin
      req1_a = q1[0].a;
      req1_b = q1[0].b;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (acc0 && q0.size() > 0) q0.delete(0);
    if (acc1 && q1.size() > 0) q1.delete(0);
    drive();
  endtask

  task automatic push0(input logic [31:0] a, input logic [31:0] b);
    q0.push_back('{a: a, b: b});
    drive();
  endtask

  task automatic push1(input logic [31:0] a, input logic [31:0] b);
    q1.push_back('{a: a, b: b});
    drive();
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(3))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    for (int i = 0; i < L; i++) mp[i] = '0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0;
    req0_b = '0;
    req1_a = '0;
    req1_b = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_data", resp_data, 0);

    // single request
    tick();
    push0(32'd3423, 32'd3413);
    @(negedge clk);
    chk("single_ready", req0_ready, 1);
    repeat (5) tick();
    @(negedge clk);
    chk("single_v", resp0_valid, 1);
    chk("single_data", resp_data, 64'd11682699);
    tick();
    @(negedge clk);
    chk("single_idle", busy, 0);

    // width boundary
    tick();
    push0(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push0(32'h0, 32'hFFFF_FFFF);
    repeat (5) tick();
    @(negedge clk);
    chk("max_data", resp_data, 64'hFFFF_FFFE_0000_0001);
    tick();
    @(negedge clk);
    chk("zero_v", resp0_valid, 1);
    chk("zero_data", resp_data, 0);

    // mid-flight reset
    repeat (3) tick();
    push0(32'd5, 32'd7);
    push0(32'd9, 32'd11);
    push0(32'd13, 32'd17);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      if (i == 0) chk("rst_flush_busy", busy, 0);
      n += int'(resp0_valid) + int'(resp1_valid);
    end
    chk("rst_no_resp", n, 0);

    // tie after reset
    tick();
    push0(32'd7, 32'd6);
    push1(32'd1000, 32'd1000);
    @(negedge clk);
    chk("tie_r0", req0_ready, 1);
    chk("tie_r1", req1_ready, 0);
    repeat (5) tick();
    @(negedge clk);
    chk("tie_d0", resp_data, 64'd42);
    tick();
    @(negedge clk);
    chk("tie_v1", resp1_valid, 1);
    chk("tie_d1", resp_data, 64'd1000000);

    // sustained contention
    tick();
    for (int i = 0; i < 4; i++) begin
      push0($urandom, $urandom);
      push1($urandom, $urandom);
    end
    @(negedge clk);
    chk("cont_first", req0_ready, 1);
    repeat (4) tick();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge clk);
      n += int'(resp0_valid) + int'(resp1_valid);
    end
    chk("cont_no_bubble", n, 8);

    // idle
    repeat (10) tick();
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(400) == 0) rst_n = 1'b0;
      if ($urandom_range(2) == 0 && q0.size() < 3) push0(rnd(), rnd());
      if ($urandom_range(2) == 0 && q1.size() < 3) push1(rnd(), rnd());
    end
    rst_n = 1'b1;
    q0.delete();
    q1.delete();
    repeat (L + 4) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
